// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision sequential divider.
// Holds the field widths, the exponent bias and the canonical quiet NaN.
// Also holds the FSM state encoding and the operand classification helpers.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int MANT_W = FRAC_W + 1;   // hidden bit + stored fraction
  localparam int QUO_W  = MANT_W + 1;   // one extra quotient bit for a/b in (0.5, 2)
  localparam int E_W    = 10;           // signed working exponent

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIVIDE = 3'd2,
    NORM   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Denormals are flushed: any zero exponent counts as zero.
  function automatic logic is_zero(input logic [31:0] x);
    return x[FRAC_W +: EXP_W] == '0;
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[FRAC_W +: EXP_W] == '1) && (x[FRAC_W-1:0] == '0);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[FRAC_W +: EXP_W] == '1) && (x[FRAC_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp_mant_divider.sv
// Iterative restoring mantissa divider, one quotient bit per step.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - capture dividend/divisor and clear the quotient
//   dividend  - 24-bit mantissa of a (hidden bit set)
//   divisor   - 24-bit mantissa of b (hidden bit set)
//   step      - perform one compare/subtract/shift iteration
//   quotient  - accumulated quotient; after 25 steps bit 24 has weight 2^0
module fp_mant_divider
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [MANT_W-1:0] dividend,
  input  logic [MANT_W-1:0] divisor,
  input  logic              step,
  output logic [QUO_W-1:0]  quotient
);

  // The remainder stays below 2*divisor, so one bit beyond the mantissa
  // width is enough to hold it after each shift.
  logic [QUO_W-1:0]  rem_reg;
  logic [MANT_W-1:0] divisor_reg;
  logic [QUO_W-1:0]  quo_reg;

  logic              ge;
  logic [QUO_W-1:0]  diff;
  logic [QUO_W-1:0]  rem_shift;

  always_comb begin
    ge        = rem_reg >= {1'b0, divisor_reg};
    diff      = ge ? (rem_reg - {1'b0, divisor_reg}) : rem_reg;
    // After the restore step diff < divisor, so its top bit is always zero.
    rem_shift = {diff[QUO_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg     <= '0;
      divisor_reg <= '0;
      quo_reg     <= '0;
    end else if (load) begin
      rem_reg     <= {1'b0, dividend};
      divisor_reg <= divisor;
      quo_reg     <= '0;
    end else if (step) begin
      rem_reg     <= rem_shift;
      quo_reg     <= {quo_reg[QUO_W-2:0], ge};
    end
  end

  assign quotient = quo_reg;

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider, result = a / b.
// Restoring division, one quotient bit per clock, truncating rounding,
// denormals flushed to zero.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   start        - request, only sampled while idle
//   a, b         - dividend and divisor, captured on an accepted start
//   busy         - operation in flight
//   done         - one-cycle pulse when result and flags are valid
//   result       - quotient, held until the next completion
//   div_by_zero  - finite nonzero a divided by zero
//   invalid      - 0/0, Inf/Inf or a NaN operand
module fp_divider_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        invalid
);

  state_t                state_reg, state_next;
  logic [31:0]           a_reg, a_next;
  logic [31:0]           b_reg, b_next;
  logic                  sign_reg, sign_next;
  logic signed [E_W-1:0] exp_reg, exp_next;
  logic [4:0]            count_reg, count_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic [31:0]           result_reg, result_next;
  logic                  dbz_reg, dbz_next;
  logic                  inv_reg, inv_next;
  // Outcome computed in UNPACK or NORM, published together with done.
  logic [31:0]           pend_res_reg, pend_res_next;
  logic                  pend_dbz_reg, pend_dbz_next;
  logic                  pend_inv_reg, pend_inv_next;

  logic                  mant_load;
  logic                  mant_step;
  logic [QUO_W-1:0]      quotient;

  logic                  a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic signed [E_W-1:0] e_calc;
  logic signed [E_W-1:0] e_adj;
  logic [FRAC_W-1:0]     frac;

  fp_mant_divider u_mant (
    .clk      (clk),
    .rst      (rst),
    .load     (mant_load),
    .dividend ({1'b1, a_reg[FRAC_W-1:0]}),
    .divisor  ({1'b1, b_reg[FRAC_W-1:0]}),
    .step     (mant_step),
    .quotient (quotient)
  );

  always_comb begin
    a_zero = is_zero(a_reg);
    a_inf  = is_inf(a_reg);
    a_nan  = is_nan(a_reg);
    b_zero = is_zero(b_reg);
    b_inf  = is_inf(b_reg);
    b_nan  = is_nan(b_reg);
    e_calc = $signed({2'b00, a_reg[FRAC_W +: EXP_W]})
           - $signed({2'b00, b_reg[FRAC_W +: EXP_W]})
           + $signed(E_W'(BIAS));
    // A quotient below 1.0 needs one left shift, costing one exponent step.
    e_adj  = quotient[QUO_W-1] ? exp_reg : (exp_reg - $signed(E_W'(1)));
    frac   = quotient[QUO_W-1] ? quotient[FRAC_W:1] : quotient[FRAC_W-1:0];
  end

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    sign_next     = sign_reg;
    exp_next      = exp_reg;
    count_next    = count_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    result_next   = result_reg;
    dbz_next      = dbz_reg;
    inv_next      = inv_reg;
    pend_res_next = pend_res_reg;
    pend_dbz_next = pend_dbz_reg;
    pend_inv_next = pend_inv_reg;
    mant_load     = 1'b0;
    mant_step     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          busy_next  = 1'b1;
          dbz_next   = 1'b0;
          inv_next   = 1'b0;
          state_next = UNPACK;
        end
      end

      UNPACK: begin
        sign_next     = a_reg[31] ^ b_reg[31];
        exp_next      = e_calc;
        pend_dbz_next = 1'b0;
        pend_inv_next = 1'b0;
        state_next    = DONE;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          pend_res_next = QNAN;
          pend_inv_next = 1'b1;
        end else if (b_zero && !a_inf) begin
          pend_res_next = {a_reg[31] ^ b_reg[31], {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          pend_dbz_next = 1'b1;
        end else if (a_inf || b_zero) begin
          pend_res_next = {a_reg[31] ^ b_reg[31], {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (a_zero || b_inf) begin
          pend_res_next = {a_reg[31] ^ b_reg[31], 31'd0};
        end else begin
          mant_load  = 1'b1;
          count_next = 5'd0;
          state_next = DIVIDE;
        end
      end

      DIVIDE: begin
        mant_step  = 1'b1;
        count_next = count_reg + 5'd1;
        if (count_reg == 5'd24) begin
          state_next = NORM;
        end
      end

      NORM: begin
        if (e_adj >= $signed(E_W'(255))) begin
          pend_res_next = {sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (e_adj <= $signed(E_W'(0))) begin
          pend_res_next = {sign_reg, 31'd0};
        end else begin
          pend_res_next = {sign_reg, e_adj[EXP_W-1:0], frac};
        end
        state_next = DONE;
      end

      DONE: begin
        done_next   = 1'b1;
        busy_next   = 1'b0;
        result_next = pend_res_reg;
        dbz_next    = pend_dbz_reg;
        inv_next    = pend_inv_reg;
        state_next  = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      sign_reg     <= 1'b0;
      exp_reg      <= '0;
      count_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      dbz_reg      <= 1'b0;
      inv_reg      <= 1'b0;
      pend_res_reg <= '0;
      pend_dbz_reg <= 1'b0;
      pend_inv_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      sign_reg     <= sign_next;
      exp_reg      <= exp_next;
      count_reg    <= count_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      result_reg   <= result_next;
      dbz_reg      <= dbz_next;
      inv_reg      <= inv_next;
      pend_res_reg <= pend_res_next;
      pend_dbz_reg <= pend_dbz_next;
      pend_inv_reg <= pend_inv_next;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign result      = result_reg;
  assign div_by_zero = dbz_reg;
  assign invalid     = inv_reg;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed testbench for fp_divider_seq with hand-computed expected values.
module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;
  logic        invalid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_divider_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .invalid     (invalid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Runs one division. Latency is counted in edges from the accepting edge
  // to the first sample where done is high. When inject is set, a competing
  // start is presented for the edge T+5 while the divider is busy.
  task automatic run_div(input string name, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp_res, input logic exp_dbz, input logic exp_inv,
                         input int exp_lat, input logic inject);
    int lat;
    lat = 99;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = '0;
    b = '0;
    check({name, ".busy"}, {31'd0, busy}, 32'd1);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (inject && n == 4) begin
        a = 32'h3F80_0000;
        b = 32'h4040_0000;
        start = 1'b1;
      end else if (inject && n == 5) begin
        start = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    check({name, ".latency"}, lat, exp_lat);
    check({name, ".result"}, result, exp_res);
    check({name, ".dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    check({name, ".inv"}, {31'd0, invalid}, {31'd0, exp_inv});
    check({name, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    $display("txn %-10s a=0x%08h b=0x%08h result=0x%08h dbz=%0d inv=%0d lat=%0d",
             name, va, vb, result, div_by_zero, invalid, lat);
    @(posedge clk);
    #1;
    check({name, ".done_pulse"}, {31'd0, done}, 32'd0);
    check({name, ".held"}, result, exp_res);
  endtask

  initial begin
    int seen_done;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.flags", {30'd0, div_by_zero, invalid}, 32'd0);
    rst = 1'b0;

    run_div("6/2",      32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 28, 1'b0);
    run_div("1/3",      32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0, 28, 1'b0);
    run_div("-7.5/0.5", 32'hC0F0_0000, 32'h3F00_0000, 32'hC170_0000, 1'b0, 1'b0, 28, 1'b0);
    run_div("1/0",      32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0, 2,  1'b0);
    run_div("0/0",      32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2,  1'b0);
    run_div("inf/inf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2,  1'b0);
    run_div("nan/2",    32'h7F80_0001, 32'h4000_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2,  1'b0);
    run_div("-inf/2",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b0, 2,  1'b0);
    run_div("inf/0",    32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0, 2,  1'b0);
    run_div("3/-inf",   32'h4040_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0, 2,  1'b0);
    run_div("ovf",      32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 1'b0, 28, 1'b0);
    run_div("unf",      32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b0, 28, 1'b0);
    run_div("busy_ign", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 28, 1'b1);
    // The start right after a completion must be accepted.
    run_div("next",     32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 1'b0, 28, 1'b0);
    run_div("-7.5/0.5b",32'hC0F0_0000, 32'h3F00_0000, 32'hC170_0000, 1'b0, 1'b0, 28, 1'b0);

    // Abort mid-divide: reset is sampled at edge T+10.
    @(negedge clk);
    a = 32'h40C0_0000;
    b = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.result", result, 32'd0);
    check("abort.done", {31'd0, done}, 32'd0);
    seen_done = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    check("abort.no_done", seen_done, 0);
    $display("txn abort      reset at T+10 busy=%0d result=0x%08h done_seen=%0d",
             busy, result, seen_done);
    run_div("post_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 28, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
